// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: opcode offsets, control-bit indices and instruction classes.
package decode_pkg;

    // Non-R opcodes sit directly above the last R-type opcode
    localparam int unsigned OPC_BEQ_OFS   = 1;
    localparam int unsigned OPC_LOAD_OFS  = 2;
    localparam int unsigned OPC_STORE_OFS = 3;

    localparam int unsigned CTRL_W    = 5;
    localparam int unsigned CTRL_REGW = 0;
    localparam int unsigned CTRL_MRD  = 1;
    localparam int unsigned CTRL_MWR  = 2;
    localparam int unsigned CTRL_BR   = 3;
    localparam int unsigned CTRL_ILL  = 4;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_BEQ,
        CLS_LOAD,
        CLS_STORE,
        CLS_ILL
    } instr_class_e;

endpackage

// File: rtl/instr_decode_stage_field_decode.sv
// Combinational field split, immediate extension and control generation.
// Sign extension of the immediate is selected by DECODE_SIGN_EXT_EN.
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned IMM_W     = 8,
    parameter int unsigned R_MAX_OPC = 4
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_AW-1:0]  rs1,
    output logic [REG_AW-1:0]  rs2,
    output logic [REG_AW-1:0]  rd,
    output logic [IMM_W-1:0]   imm,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               uses_rs2
);

    localparam int unsigned FLD_W = INSTR_W - OPC_W - 2*REG_AW;

    localparam logic [OPC_W-1:0] OPC_R_MAX = OPC_W'(R_MAX_OPC);
    localparam logic [OPC_W-1:0] OPC_BEQ   = OPC_W'(R_MAX_OPC + OPC_BEQ_OFS);
    localparam logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(R_MAX_OPC + OPC_LOAD_OFS);
    localparam logic [OPC_W-1:0] OPC_STORE = OPC_W'(R_MAX_OPC + OPC_STORE_OFS);

    logic [FLD_W-1:0] low;
    logic [IMM_W-1:0] imm_ext;
    instr_class_e     cls;

    assign opcode = instr[INSTR_W-1 -: OPC_W];
    assign rs1    = instr[INSTR_W-OPC_W-1 -: REG_AW];
    assign rs2    = instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign low    = instr[FLD_W-1:0];

`ifdef DECODE_SIGN_EXT_EN
    assign imm_ext = IMM_W'($signed(low));
`else
    assign imm_ext = IMM_W'(low);
`endif

    always_comb begin
        cls = CLS_ILL;
        if (opcode <= OPC_R_MAX)       cls = CLS_R;
        else if (opcode == OPC_BEQ)    cls = CLS_BEQ;
        else if (opcode == OPC_LOAD)   cls = CLS_LOAD;
        else if (opcode == OPC_STORE)  cls = CLS_STORE;
    end

    always_comb begin
        rd       = '0;
        imm      = '0;
        ctrl     = '0;
        uses_rs2 = 1'b0;
        case (cls)
            CLS_R: begin
                rd              = low[REG_AW-1:0];
                ctrl[CTRL_REGW] = 1'b1;
                uses_rs2        = 1'b1;
            end
            CLS_BEQ: begin
                imm           = imm_ext;
                ctrl[CTRL_BR] = 1'b1;
                uses_rs2      = 1'b1;
            end
            CLS_LOAD: begin
                rd              = rs2;
                imm             = imm_ext;
                ctrl[CTRL_REGW] = 1'b1;
                ctrl[CTRL_MRD]  = 1'b1;
            end
            CLS_STORE: begin
                imm            = imm_ext;
                ctrl[CTRL_MWR] = 1'b1;
                uses_rs2       = 1'b1;
            end
            default: begin
                ctrl[CTRL_ILL] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with valid/ready handshakes, flush and load-use bubble.
// DECODE_SIGN_EXT_EN selects sign-extended immediates in the field decoder.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned OPC_W     = 4,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned IMM_W     = 8,
    parameter int unsigned R_MAX_OPC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [REG_AW-1:0]  out_rd,
    output logic [IMM_W-1:0]   out_imm,
    output logic [4:0]         out_ctrl
);

    logic [OPC_W-1:0]  dec_opcode;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic [IMM_W-1:0]  dec_imm;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_uses_rs2;
    logic              hazard;
    logic              accept;

    instr_field_decode #(
        .INSTR_W   (INSTR_W),
        .OPC_W     (OPC_W),
        .REG_AW    (REG_AW),
        .IMM_W     (IMM_W),
        .R_MAX_OPC (R_MAX_OPC)
    ) u_field_decode (
        .instr    (in_instr),
        .opcode   (dec_opcode),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .imm      (dec_imm),
        .ctrl     (dec_ctrl),
        .uses_rs2 (dec_uses_rs2)
    );

    // Stalling while the load is held and then waiting for the empty register yields one bubble
    assign hazard = out_valid & out_ctrl[CTRL_MRD] &
                    ((dec_rs1 == out_rd) | (dec_uses_rs2 & (dec_rs2 == out_rd)));

    assign in_ready = rst_n & ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_imm    <= '0;
            out_ctrl   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= dec_opcode;
            out_rs1    <= dec_rs1;
            out_rs2    <= dec_rs2;
            out_rd     <= dec_rd;
            out_imm    <= dec_imm;
            out_ctrl   <= dec_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (default parameters).
module tb_instr_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [3:0]  out_rs1;
    logic [3:0]  out_rs2;
    logic [3:0]  out_rd;
    logic [7:0]  out_imm;
    logic [4:0]  out_ctrl;

    int tests;
    int fails;

    instr_decode_stage #(
        .INSTR_W   (16),
        .OPC_W     (4),
        .REG_AW    (4),
        .IMM_W     (8),
        .R_MAX_OPC (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_ctrl   (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change and are checked on the falling edge, away from the active edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        step();
        tests++;
        if ({out_valid, out_opcode, out_rs1, out_rs2, out_rd, out_imm, out_ctrl} !== '0) begin
            fails++; $display("FAIL reset_outputs: got valid=%b ctrl=%b rd=%h imm=%h, want all 0",
                              out_valid, out_ctrl, out_rd, out_imm);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        in_valid = 1'b1; in_instr = 16'h0123; out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL add_accept: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_rs1, out_rs2, out_rd, out_imm, out_ctrl} !== {1'b1, 4'h1, 4'h2, 4'h3, 8'h00, 5'b00001}) begin
            fails++; $display("FAIL add_bundle: got v=%b rs1=%h rs2=%h rd=%h imm=%h ctrl=%b want 1 1 2 3 00 00001",
                              out_valid, out_rs1, out_rs2, out_rd, out_imm, out_ctrl);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL add_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = 16'h6125; out_ready = 1'b1;
        step();
        in_instr = 16'h0234;
        #1;
        tests++;
        if ({out_valid, out_rd, out_imm, out_ctrl} !== {1'b1, 4'h2, 8'h05, 5'b00011}) begin
            fails++; $display("FAIL load_bundle: got v=%b rd=%h imm=%h ctrl=%b want 1 2 05 00011",
                              out_valid, out_rd, out_imm, out_ctrl);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL load_use_stall: in_ready=%b want 0", in_ready);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL load_use_bubble: out_valid=%b want 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL load_use_resume: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_rs1, out_rs2, out_rd, out_ctrl} !== {1'b1, 4'h2, 4'h3, 4'h4, 5'b00001}) begin
            fails++; $display("FAIL load_use_dependent: got v=%b rs1=%h rs2=%h rd=%h ctrl=%b want 1 2 3 4 00001",
                              out_valid, out_rs1, out_rs2, out_rd, out_ctrl);
        end
        step();
    endtask

    task automatic test_beq();
        logic [7:0] exp_imm;
`ifdef DECODE_SIGN_EXT_EN
        exp_imm = 8'hFF;
`else
        exp_imm = 8'h0F;
`endif
        in_valid = 1'b1; in_instr = 16'h512F; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_rd, out_imm, out_ctrl} !== {1'b1, 4'h0, exp_imm, 5'b01000}) begin
            fails++; $display("FAIL beq_bundle: got v=%b rd=%h imm=%h ctrl=%b want 1 0 %h 01000",
                              out_valid, out_rd, out_imm, out_ctrl, exp_imm);
        end
        step();
    endtask

    task automatic test_store();
        in_valid = 1'b1; in_instr = 16'h7A3C; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_rs1, out_rs2, out_rd, out_ctrl} !== {1'b1, 4'hA, 4'h3, 4'h0, 5'b00100}) begin
            fails++; $display("FAIL store_bundle: got v=%b rs1=%h rs2=%h rd=%h ctrl=%b want 1 a 3 0 00100",
                              out_valid, out_rs1, out_rs2, out_rd, out_ctrl);
        end
        step();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 16'h9ABC; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_opcode, out_rd, out_imm, out_ctrl} !== {1'b1, 4'h9, 4'h0, 8'h00, 5'b10000}) begin
            fails++; $display("FAIL illegal_bundle: got v=%b opc=%h rd=%h imm=%h ctrl=%b want 1 9 0 00 10000",
                              out_valid, out_opcode, out_rd, out_imm, out_ctrl);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL illegal_transfer: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_instr = 16'h0123; out_ready = 1'b0;
        step();
        in_instr = 16'h0456;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({out_valid, out_rd, out_ctrl, in_ready} !== {1'b1, 4'h3, 5'b00001, 1'b0}) begin
                fails++; $display("FAIL backpressure_hold[%0d]: got v=%b rd=%h ctrl=%b in_ready=%b want 1 3 00001 0",
                                  i, out_valid, out_rd, out_ctrl, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL backpressure_release: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if ({out_valid, out_rd} !== {1'b1, 4'h6}) begin
            fails++; $display("FAIL backpressure_next: got v=%b rd=%h want 1 6", out_valid, out_rd);
        end
        step();
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 16'h0123; out_ready = 1'b1;
        step();
        flush = 1'b1; in_instr = 16'h0789; out_ready = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_in_ready: in_ready=%b want 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_clear: out_valid=%b want 0", out_valid);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_no_accept: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_instr = 16'h6125; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_rd, out_imm, out_ctrl, in_ready} !== '0) begin
            fails++; $display("FAIL reset_mid: got v=%b rd=%h imm=%h ctrl=%b in_ready=%b want all 0",
                              out_valid, out_rd, out_imm, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_mid_after: out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_load_use();
        test_beq();
        test_store();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
